mmio_uart_tx: RTL and testbench

Memory-mapped UART transmitter on the core's data-memory port, alongside `dmem`. It decodes store accesses (address, write data, write enable, byte enables) to a small register window. Written bytes are buffered in a FIFO and serialised 8N1, LSB first, on `tx`. A combinational status read lets software poll for FIFO space.

---
 rtl/mmio_uart_tx_pkg.sv | 22 ++
 rtl/mmio_uart_tx_sync_fifo.sv | 57 +++++
 rtl/mmio_uart_tx.sv | 191 +++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_uart_tx_pkg.sv
// Shared types and register-map constants for the memory-mapped UART transmitter.
package uart_pkg;

  // Transmit frame sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  // Register offsets inside the 8-byte window.
  localparam logic [2:0] TXDATA_OFS = 3'd0;
  localparam logic [2:0] STATUS_OFS = 3'd4;

  // STATUS register bit positions.
  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_OVF   = 3;

endpackage

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Single-clock FIFO with a combinational head word; occupancy tracked by a
// count one bit wider than the pointers so full and empty are unambiguous.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign full  = (r_count == CNT_W'(DEPTH));
  assign empty = (r_count == '0);
  assign dout  = r_mem[r_rd_ptr];

  // A push into a full FIFO is only taken when the head leaves on the same edge.
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);

  // Storage array; contents need no reset because the count gates visibility.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

  // Pointers wrap naturally; count moves only when exactly one side is active.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: store decode, TX FIFO, sticky overflow
// flag and the frame sequencer that drives a registered serial line.
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
  parameter int          CLKS_PER_BIT = 868,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        we,
  input  logic [3:0]  byteEnable,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        hit,
  output logic        tx
);

  localparam int              BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  uart_state_t       r_state;
  uart_state_t       w_state_n;
  logic [BAUD_W-1:0] r_baud;
  logic [BAUD_W-1:0] w_baud_n;
  logic [2:0]        r_bit;
  logic [2:0]        w_bit_n;
  logic [7:0]        r_shift;
  logic [7:0]        w_shift_n;
  logic              r_tx;
  logic              w_tx_n;
  logic              r_ovf;

  logic              w_hit;
  logic              w_sel_txdata;
  logic              w_sel_status;
  logic              w_push_req;
  logic              w_push;
  logic              w_pop;
  logic              w_ovf_set;
  logic              w_ovf_clr;
  logic              w_full;
  logic              w_empty;
  logic              w_busy;
  logic              w_bit_end;
  logic [7:0]        w_head;
  logic [31:0]       w_status;
  logic              w_unused;

  // Address decode: a[1:0] never matters, a[2] picks the register.
  assign w_hit        = (a[31:3] == BASE_ADDR[31:3]);
  assign w_sel_txdata = (a[2] == TXDATA_OFS[2]);
  assign w_sel_status = (a[2] == STATUS_OFS[2]);
  assign w_push_req   = we & w_hit & w_sel_txdata & byteEnable[0];
  assign w_ovf_clr    = we & w_hit & w_sel_status & byteEnable[0] & wd[3];

  // A byte arriving at a full FIFO survives only if the sequencer pops now.
  assign w_push    = w_push_req & (~w_full | w_pop);
  assign w_ovf_set = w_push_req & w_full & ~w_pop;

  assign w_busy    = (r_state != IDLE);
  assign w_bit_end = (r_baud == BAUD_LAST);
  assign hit       = w_hit;
  assign tx        = r_tx;

  // Upper data bits, alignment bits and upper byte lanes carry no meaning here.
  assign w_unused = ^{wd[31:8], a[1:0], byteEnable[3:1]};

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .clr   (clr),
    .push  (w_push),
    .pop   (w_pop),
    .din   (wd[7:0]),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty)
  );

  // STATUS word assembly and read mux; TXDATA and misses read as zero.
  always_comb begin
    w_status           = '0;
    w_status[ST_FULL]  = w_full;
    w_status[ST_EMPTY] = w_empty;
    w_status[ST_BUSY]  = w_busy;
    w_status[ST_OVF]   = r_ovf;
    rd                 = (w_hit && w_sel_status) ? w_status : '0;
  end

  // Sticky overflow flag; a simultaneous set takes priority over the clear.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr)           r_ovf <= 1'b0;
    else if (w_ovf_set) r_ovf <= 1'b1;
    else if (w_ovf_clr) r_ovf <= 1'b0;
  end

  // Sequencer control state, baud counter, bit index and line level.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state <= IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_n;
      r_baud  <= w_baud_n;
      r_bit   <= w_bit_n;
      r_tx    <= w_tx_n;
    end
  end

  // Shift register holds data only, so it carries no reset.
  always_ff @(posedge clk) begin
    r_shift <= w_shift_n;
  end

  // Next-state logic; the line level for the coming cycle is decided here so
  // the output flop never glitches.
  always_comb begin
    w_state_n = r_state;
    w_baud_n  = r_baud;
    w_bit_n   = r_bit;
    w_shift_n = r_shift;
    w_tx_n    = r_tx;
    w_pop     = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_tx_n = 1'b1;
        if (!w_empty) begin
          w_pop     = 1'b1;
          w_shift_n = w_head;
          w_baud_n  = '0;
          w_bit_n   = '0;
          w_state_n = START;
          w_tx_n    = 1'b0;
        end
      end
      START: begin
        if (w_bit_end) begin
          w_baud_n  = '0;
          w_state_n = DATA;
          w_tx_n    = r_shift[0];
        end else begin
          w_baud_n = r_baud + BAUD_W'(1);
        end
      end
      DATA: begin
        if (w_bit_end) begin
          w_baud_n  = '0;
          w_shift_n = {1'b0, r_shift[7:1]};
          if (r_bit == 3'd7) begin
            w_state_n = STOP;
            w_tx_n    = 1'b1;
          end else begin
            w_bit_n = r_bit + 3'd1;
            w_tx_n  = r_shift[1];
          end
        end else begin
          w_baud_n = r_baud + BAUD_W'(1);
        end
      end
      STOP: begin
        if (w_bit_end) begin
          w_baud_n = '0;
          if (!w_empty) begin
            w_pop     = 1'b1;
            w_shift_n = w_head;
            w_bit_n   = '0;
            w_state_n = START;
            w_tx_n    = 1'b0;
          end else begin
            w_state_n = IDLE;
            w_tx_n    = 1'b1;
          end
        end else begin
          w_baud_n = r_baud + BAUD_W'(1);
        end
      end
      default: begin
        w_state_n = IDLE;
        w_tx_n    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: decode vector table, directed frame sequences and a
// randomized run against a frame-level reference model.
module tb_mmio_uart_tx;

  localparam int          C    = 4;
  localparam int          D    = 4;
  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam int          FRAME = 10 * C;

  logic        clk = 1'b0;
  logic        clr;
  logic        we;
  logic [3:0]  byteEnable;
  logic [31:0] a;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        hit;
  logic        tx;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mmio_uart_tx #(
    .BASE_ADDR    (BASE),
    .CLKS_PER_BIT (C),
    .FIFO_DEPTH   (D)
  ) dut (
    .clk        (clk),
    .clr        (clr),
    .we         (we),
    .byteEnable (byteEnable),
    .a          (a),
    .wd         (wd),
    .rd         (rd),
    .hit        (hit),
    .tx         (tx)
  );

  // Reference model: pending bytes, frame in flight and its position.
  logic [7:0] q[$];
  bit         m_busy;
  int         m_pos;
  logic [7:0] m_cur;
  bit         m_ovf;

  function automatic void model_reset();
    q.delete();
    m_busy = 0;
    m_pos  = 0;
    m_ovf  = 0;
  endfunction

  function automatic logic m_tx();
    int slot;
    if (!m_busy) return 1'b1;
    slot = m_pos / C;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return m_cur[slot-1];
    return 1'b1;
  endfunction

  function automatic logic [31:0] m_status();
    return {27'b0, 1'b0, m_ovf, m_busy, (q.size() == 0), (q.size() == D)};
  endfunction

  function automatic void model_edge(input logic we_i, input logic [3:0] be_i,
                                     input logic [31:0] a_i, input logic [31:0] wd_i);
    bit hit_i, push_req, clr_req, pop, ovf_set;
    int pre;
    hit_i    = (a_i[31:3] == BASE[31:3]);
    push_req = we_i && hit_i && !a_i[2] && be_i[0];
    clr_req  = we_i && hit_i && a_i[2] && be_i[0] && wd_i[3];
    pre      = q.size();
    pop      = (pre > 0) && (!m_busy || m_pos == FRAME - 1);
    ovf_set  = 0;
    if (m_busy && m_pos != FRAME - 1) begin
      m_pos++;
    end else if (pop) begin
      m_cur  = q.pop_front();
      m_pos  = 0;
      m_busy = 1;
    end else begin
      m_busy = 0;
    end
    if (push_req) begin
      if (pre < D || pop) q.push_back(wd_i[7:0]);
      else ovf_set = 1;
    end
    if (ovf_set) m_ovf = 1;
    else if (clr_req) m_ovf = 0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Inputs are set at a falling edge; this checks the combinational read,
  // applies one rising edge to DUT and model, then checks the line.
  task automatic cycle();
    logic        e_hit;
    logic [31:0] e_rd;
    #1;
    e_hit = (a[31:3] == BASE[31:3]);
    e_rd  = (e_hit && a[2]) ? m_status() : 32'h0;
    chk("hit", hit, e_hit);
    chk("rd", rd, e_rd);
    @(posedge clk);
    model_edge(we, byteEnable, a, wd);
    @(negedge clk);
    chk("tx", tx, m_tx());
  endtask

  task automatic set_in(input logic w, input logic [3:0] be, input logic [31:0] ad,
                        input logic [31:0] d);
    we = w; byteEnable = be; a = ad; wd = d;
  endtask

  task automatic rd_status();
    set_in(1'b0, 4'h0, BASE + 32'd4, 32'h0);
  endtask

  task automatic store(input logic [7:0] b);
    set_in(1'b1, 4'b0001, BASE, {24'hABCDEF, b});
    cycle();
  endtask

  task automatic drain(input int n);
    rd_status();
    for (int i = 0; i < n; i++) cycle();
  endtask

  typedef struct {
    logic        w;
    logic [3:0]  be;
    logic [31:0] ad;
    logic [31:0] d;
    logic [31:0] exp_rd;
    logic        exp_hit;
  } vec_t;

  vec_t vt[8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] b55;
    logic       ok;
    int         exp_bit;

    clr = 1'b0;
    set_in(1'b0, 4'h0, 32'h0, 32'h0);
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_tx", tx, 1'b1);
    clr = 1'b1;
    rd_status();
    #1;
    chk("reset_status", rd, 32'h2);

    // Decode table: none of these may alter state; STATUS stays 2.
    vt[0] = '{1'b0, 4'h0, BASE + 32'd4, 32'h0,        32'h2, 1'b1};
    vt[1] = '{1'b0, 4'h0, BASE,         32'h0,        32'h0, 1'b1};
    vt[2] = '{1'b0, 4'h0, BASE + 32'd7, 32'h0,        32'h2, 1'b1};
    vt[3] = '{1'b0, 4'h0, BASE + 32'd8, 32'h0,        32'h0, 1'b0};
    vt[4] = '{1'b1, 4'hF, BASE + 32'd8, 32'h55,       32'h0, 1'b0};
    vt[5] = '{1'b1, 4'b0010, BASE,      32'h5555,     32'h0, 1'b1};
    vt[6] = '{1'b0, 4'h0, BASE - 32'd4, 32'h0,        32'h0, 1'b0};
    vt[7] = '{1'b0, 4'h0, BASE + 32'd5, 32'h0,        32'h2, 1'b1};
    for (int i = 0; i < 8; i++) begin
      set_in(vt[i].w, vt[i].be, vt[i].ad, vt[i].d);
      #1;
      chk($sformatf("vec%0d_rd", i), rd, vt[i].exp_rd);
      chk($sformatf("vec%0d_hit", i), hit, vt[i].exp_hit);
      cycle();
    end
    rd_status();
    drain(2);
    chk("table_status", rd, 32'h2);

    // Single 0x55 frame with explicit bit pattern and busy flag.
    b55 = 8'h55;
    store(8'h55);
    rd_status();
    for (int k = 0; k < FRAME; k++) begin
      cycle();
      if (k < C) exp_bit = 0;
      else if (k >= 9 * C) exp_bit = 1;
      else exp_bit = int'(b55[(k / C) - 1]);
      chk("A_tx", tx, exp_bit[0]);
      chk("A_busy", rd[2], 1'b1);
    end
    cycle();
    chk("A_done", rd, 32'h2);

    // Six stores: one in flight, four buffered, one dropped.
    for (int i = 1; i <= 6; i++) store(i[7:0]);
    rd_status();
    #1;
    chk("B_status", rd, 32'hD);
    drain(5 * FRAME + 10);
    chk("B_after", rd, 32'hA);

    // Overflow clear through a STATUS write.
    set_in(1'b1, 4'b0001, BASE + 32'd4, 32'h8);
    cycle();
    rd_status();
    #1;
    chk("C_ovf_clr", rd, 32'h2);

    // Push into a full FIFO on the edge that moves STOP to START.
    for (int i = 0; i < 5; i++) store(8'h11 + i[7:0]);
    rd_status();
    ok = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      if (m_busy && m_pos == FRAME - 1) begin
        ok = 1;
        break;
      end
      cycle();
    end
    chk("D_wait", ok, 1'b1);
    store(8'hA5);
    rd_status();
    #1;
    chk("D_status", rd, 32'h5);
    drain(6 * FRAME);
    chk("D_after", rd, 32'h2);

    // Reset asserted mid-DATA.
    store(8'h00);
    rd_status();
    ok = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (m_busy && m_pos == 3 * C) begin
        ok = 1;
        break;
      end
      cycle();
    end
    chk("E_wait", ok, 1'b1);
    chk("E_tx_low", tx, 1'b0);
    clr = 1'b0;
    #1;
    chk("E_tx_async", tx, 1'b1);
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    clr = 1'b1;
    #1;
    chk("E_status", rd, 32'h2);
    drain(2 * FRAME);
    chk("E_quiet", rd, 32'h2);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      int op;
      op = $urandom_range(0, 99);
      if (op < 40) rd_status();
      else if (op < 75)
        set_in(1'b1, ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0001,
               BASE + 32'($urandom_range(0, 3)), $urandom);
      else if (op < 85)
        set_in(1'b1, 4'($urandom), BASE + 32'd4 + 32'($urandom_range(0, 3)), $urandom);
      else if (op < 93)
        set_in($urandom_range(0, 1) == 1, 4'($urandom), BASE + 32'($urandom_range(8, 63)), $urandom);
      else
        set_in($urandom_range(0, 1) == 1, 4'($urandom), $urandom, $urandom);
      cycle();
    end
    drain((D + 2) * FRAME);
    chk("R_idle", rd[2:1], 2'b01);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
